// File: rtl/sum_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM encoding,
// default operand size and the signed-overflow helper.
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLES_DEF = 4;

  // Overflow from the operand MSBs and the result MSB: both addends share a
  // sign and the result sign differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/sum_nibble.sv
// 4-bit ripple slice: the only arithmetic element of the serial adder.
module sum_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [4:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {4'b0000, c0};
  assign {c4, s} = total;

endmodule

// File: rtl/sum_serial16.sv
// Nibble-serial add/subtract: one nibble per clock through a shared 4-bit
// adder, result published on the last nibble with a one-cycle done pulse.
module sum_serial16
  import sum_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 sub,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic                     carry;
  logic [NIBBLES-1:0][3:0]  a_reg;
  logic [NIBBLES-1:0][3:0]  b_reg;
  logic [NIBBLES-1:0][3:0]  shadow;
  logic [NIBBLES-1:0][3:0]  shadow_next;
  logic [3:0]               nib_s;
  logic                     nib_c4;
  logic                     last_nib;
  logic                     ovf_next;

  sum_nibble u_nibble (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .c0 (carry),
    .s  (nib_s),
    .c4 (nib_c4)
  );

  // The published result needs the top nibble merged in the same edge.
  always_comb begin
    shadow_next      = shadow;
    shadow_next[idx] = nib_s;
    last_nib         = (idx == IDX_W'(NIBBLES - 1));
    ovf_next         = signed_ovf(a_reg[NIBBLES-1][3], b_reg[NIBBLES-1][3], nib_s[3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      shadow <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            a_reg <= op_a;
            b_reg <= op_b ^ {W{sub}};
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          shadow <= shadow_next;
          carry  <= nib_c4;
          idx    <= idx + 1'b1;
          if (last_nib) begin
            result <= shadow_next;
            cout   <= nib_c4;
            ovf    <= ovf_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_serial16.sv
// Scoreboard bench for sum_serial16: directed operations queue their expected
// response; a negedge monitor checks every done pulse and the CALC hold rules.
module tb_sum_serial16;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc    = 0;
  int           busy_cnt = 0;
  logic [W-1:0] hold_res  = '0;
  logic         hold_cout = 1'b0;
  logic         hold_ovf  = 1'b0;

  sum_serial16 #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .sub    (sub),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on done, checks held outputs while busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("hold_during_calc", 32'({result, cout, ovf}), 32'({hold_res, hold_cout, hold_ovf}));
      end
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: done high with nothing expected (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("cout", 32'(cout), 32'(e.co));
          check("ovf", 32'(ovf), 32'(e.ov));
          check("done_latency", 32'(cyc), 32'(e.cyc));
          check("busy_cycles", 32'(busy_cnt), 32'(NIB));
          check("busy_with_done", 32'(busy), 32'(0));
          hold_res  = e.res;
          hold_cout = e.co;
          hold_ovf  = e.ov;
        end
        busy_cnt = 0;
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_timeout: no done by cycle %0d, expected at %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  // With hold set, start stays high and operands churn while the op is in flight.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic c, input logic [W-1:0] er, input logic eco,
                       input logic eov, input logic hold);
    exp_t e;
    op_a  = a;
    op_b  = b;
    sub   = s;
    cin   = c;
    start = 1'b1;
    e.res = er;
    e.co  = eco;
    e.ov  = eov;
    e.cyc = cyc + NIB + 1;
    q.push_back(e);
    repeat (NIB + 1) begin
      @(negedge clk);
      start = hold;
      if (hold) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
        sub  = 1'($urandom);
        cin  = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    sub   = 1'b0;
    cin   = 1'b0;
    #2;
    check("reset_outputs", 32'({busy, done, result, cout, ovf}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    // Back-to-back ops with start held and inputs churning mid-flight.
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    do_op(16'hA000, 16'h2000, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    // cin must be ignored when subtracting.
    do_op(16'h0010, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Abort an op in its second CALC cycle; no done may follow.
    op_a  = 16'hFFFF;
    op_b  = 16'hFFFF;
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    hold_res  = '0;
    hold_cout = 1'b0;
    hold_ovf  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_mid_calc", 32'({busy, done, result, cout, ovf}), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum_serial16.md
SUM_SERIAL16 -- requirements
Module: sum_serial16

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of nibbles per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, requests one operation; sampled only in IDLE.
REQ-005 SHALL have port op_a, input, W, first operand, captured when start is accepted.
REQ-006 SHALL have port op_b, input, W, second operand, captured when start is accepted.
REQ-007 SHALL have port sub, input, 1: 0 selects add, 1 selects subtract (op_a - op_b); captured with the operands.
REQ-008 SHALL have port cin, input, 1, carry-in for add; captured with the operands; ignored when sub=1.
REQ-009 SHALL have port busy, output, 1, high while the operation is in progress (CALC state).
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port result, output, W, sum or difference, held until the next completion.
REQ-012 SHALL have port cout, output, 1, final carry out of the top nibble (for subtract, 1 = no borrow).
REQ-013 SHALL have port ovf, output, 1, two's-complement signed overflow of the final operation.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 IDLE: when start=1 at a rising edge, SHALL capture op_a, op_b (inverted if sub=1), sub, and carry seed (cin if add, 1 if sub); SHALL clear nibble index idx to 0; SHALL go to CALC. When start=0, SHALL stay in IDLE.
REQ-016 CALC: each edge SHALL add nibble idx of the captured operands with the carry register through one nibble adder, write the 4-bit sum into result-shadow nibble idx, store c4 as the next carry, and increment idx.
REQ-017 CALC: on the edge that processes idx = NIBBLES-1, SHALL copy the shadow register to result, set cout to the final c4, set ovf, and go to DONE.
REQ-018 ovf SHALL equal (carry into bit W-1) XOR (carry out of bit W-1); this is computed from the top-nibble MSBs: (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is the possibly inverted op_b.
REQ-019 DONE: SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+NIBBLES (edge k+4 at default).
REQ-021 busy SHALL be high exactly during CALC cycles; busy and done SHALL never be high together.
REQ-022 start SHALL be ignored in CALC and DONE; operand or sub changes during those states SHALL NOT affect the operation in flight.
REQ-023 idx SHALL be ceil(log2(NIBBLES)) bits wide; it is not used outside CALC; wrap-around SHALL have no effect.
REQ-024 result, cout and ovf SHALL change only on the CALC-to-DONE edge; during CALC they SHALL hold the previous operation's values.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, idx=0, carry=0, shadow=0, result=0, cout=0, ovf=0, busy=0, done=0, regardless of the clock.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start accepted after rst_n rises SHALL run normally.

Structure
REQ-027 The shared package/header sum_pkg SHALL hold the FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default NIBBLES constant.
REQ-028 SHALL instantiate exactly one existing sum_nibble (a, b, c0, s, c4) as the sole arithmetic element; no other adders, except for the index increment.

Verification
REQ-029 Add: op_a=16'h1234, op_b=16'h4321, cin=0, sub=0 -> result=16'h5555, cout=0, ovf=0, done 4 edges after the start edge, busy high for 4 cycles.
REQ-030 Carry chain: 16'hFFFF + 16'h0001, cin=0 -> result=16'h0000, cout=1, ovf=0; 16'hFFFF + 16'h0000, cin=1 -> 16'h0000, cout=1.
REQ-031 Signed overflow: 16'h7FFF + 16'h0001 -> result=16'h8000, cout=0, ovf=1.
REQ-032 Subtract: op_a=16'h0005, op_b=16'h0007, sub=1, cin=1 -> result=16'hFFFE, cout=0, ovf=0; then 16'h8000 - 16'h0001 -> 16'h7FFF, cout=1, ovf=1.
REQ-033 Busy/ignore: hold start=1 and change operands on every cycle during CALC -> exactly one done pulse per accepted op; result matches the operands captured at the accepting edge.
REQ-034 Reset mid-op: drop rst_n during the 2nd CALC cycle -> busy, done, result, cout and ovf go to 0 at once; no done pulse; the next 16'h0001 + 16'h0001 gives 16'h0002.
